// File: rtl/enc_4x2.sv
// Registered 4-to-2 priority encoder with valid and multi-hot error flags.
// PRIORITY_MSB picks whether the highest or lowest set request wins.
module enc_4x2 #(
    parameter bit PRIORITY_MSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] enc_i,
    output logic [1:0] enc_o,
    output logic       valid_o,
    output logic       err_o
);

    logic [1:0] enc_next;
    logic       valid_next;
    logic       err_next;

    // Priority resolution is fixed at elaboration, so only one case table survives.
    always_comb begin
        enc_next = 2'b00;
        if (PRIORITY_MSB) begin
            casez (enc_i)
                4'b1???: enc_next = 2'b11;
                4'b01??: enc_next = 2'b10;
                4'b001?: enc_next = 2'b01;
                default: enc_next = 2'b00;
            endcase
        end else begin
            casez (enc_i)
                4'b???1: enc_next = 2'b00;
                4'b??10: enc_next = 2'b01;
                4'b?100: enc_next = 2'b10;
                4'b1000: enc_next = 2'b11;
                default: enc_next = 2'b00;
            endcase
        end
    end

    // Clearing the lowest set bit leaves something only when two or more were set.
    always_comb begin
        valid_next = |enc_i;
        err_next   = |(enc_i & (enc_i - 4'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_o   <= 2'b00;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            enc_o   <= enc_next;
            valid_o <= valid_next;
            err_o   <= err_next;
        end
    end

endmodule

// File: tb/tb_enc_4x2.sv
// Directed and exhaustive checks of enc_4x2 with both priority settings
// instantiated side by side on shared inputs.
module tb_enc_4x2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] enc_i;
    logic [1:0] enc_msb, enc_lsb;
    logic       valid_msb, valid_lsb;
    logic       err_msb, err_lsb;

    int num_checks = 0;
    int num_fails  = 0;

    // Packed as {enc[1:0], valid, err}; em/el are the MSB- and LSB-priority results.
    typedef struct packed {
        logic       r;
        logic [3:0] e;
        logic [3:0] em;
        logic [3:0] el;
    } vec_t;

    vec_t       vecs [13];
    logic [3:0] prev_msb, prev_lsb, exp_msb, exp_lsb;

    always #5 clk = ~clk;

    enc_4x2 #(.PRIORITY_MSB(1'b1)) dut_msb (
        .clk    (clk),
        .rst    (rst),
        .enc_i  (enc_i),
        .enc_o  (enc_msb),
        .valid_o(valid_msb),
        .err_o  (err_msb)
    );

    enc_4x2 #(.PRIORITY_MSB(1'b0)) dut_lsb (
        .clk    (clk),
        .rst    (rst),
        .enc_i  (enc_i),
        .enc_o  (enc_lsb),
        .valid_o(valid_lsb),
        .err_o  (err_lsb)
    );

    function automatic logic [3:0] refModel(input logic r, input logic [3:0] e, input bit msb);
        int         cnt   = 0;
        logic [1:0] idx   = 2'b00;
        bit         found = 1'b0;
        if (r) return 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (e[i]) begin
                cnt++;
                if (msb || !found) idx = 2'(i);
                found = 1'b1;
            end
        end
        return {idx, cnt > 0, cnt > 1};
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: enc/valid/err got %b, required %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] e);
        @(negedge clk);
        rst   = r;
        enc_i = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs = '{
            '{1'b1, 4'b1000, 4'b0000, 4'b0000},
            '{1'b1, 4'b1000, 4'b0000, 4'b0000},
            '{1'b0, 4'b0001, 4'b0010, 4'b0010},
            '{1'b0, 4'b0010, 4'b0110, 4'b0110},
            '{1'b0, 4'b0100, 4'b1010, 4'b1010},
            '{1'b0, 4'b1000, 4'b1110, 4'b1110},
            '{1'b0, 4'b0000, 4'b0000, 4'b0000},
            '{1'b0, 4'b0110, 4'b1011, 4'b0111},
            '{1'b0, 4'b1111, 4'b1111, 4'b0011},
            '{1'b0, 4'b0100, 4'b1010, 4'b1010},
            '{1'b1, 4'b0100, 4'b0000, 4'b0000},
            '{1'b0, 4'b0100, 4'b1010, 4'b1010},
            '{1'b0, 4'b0010, 4'b0110, 4'b0110}
        };

        rst   = 1'b1;
        enc_i = 4'b1000;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].r, vecs[i].e);
            checkOutput($sformatf("dir%0d_msb", i), {enc_msb, valid_msb, err_msb}, vecs[i].em);
            checkOutput($sformatf("dir%0d_lsb", i), {enc_lsb, valid_lsb, err_lsb}, vecs[i].el);
        end

        prev_msb = 4'b0110;
        prev_lsb = 4'b0110;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            rst   = 1'b0;
            enc_i = 4'(v);
            #2;
            checkOutput($sformatf("hold%0d_msb", v), {enc_msb, valid_msb, err_msb}, prev_msb);
            checkOutput($sformatf("hold%0d_lsb", v), {enc_lsb, valid_lsb, err_lsb}, prev_lsb);
            @(posedge clk);
            #1;
            exp_msb = refModel(1'b0, 4'(v), 1'b1);
            exp_lsb = refModel(1'b0, 4'(v), 1'b0);
            checkOutput($sformatf("exh%0d_msb", v), {enc_msb, valid_msb, err_msb}, exp_msb);
            checkOutput($sformatf("exh%0d_lsb", v), {enc_lsb, valid_lsb, err_lsb}, exp_lsb);
            prev_msb = exp_msb;
            prev_lsb = exp_lsb;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/enc_4x2.md
Name: enc_4x2

Overview:
- Registered 4-to-2 binary encoder: converts a 4-bit one-hot request vector into its 2-bit index.
- Adds a valid flag and a multi-hot error flag.
- Priority resolution is deterministic when more than one input is set.
- Leaf block, used wherever a one-hot select or grant vector must be compressed to a binary code.

Parameters:
- PRIORITY_MSB, default 1. Selects which set bit wins when more than one is set: 1 = highest-index set bit wins; 0 = lowest-index set bit wins.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enc_i  input  4  one-hot request vector; bit n asserted means code n
- enc_o  output  2  encoded index, registered
- valid_o  output  1  registered; 1 when at least one enc_i bit was set
- err_o  output  1  registered; 1 when more than one enc_i bit was set

Behaviour:
- One clock domain. All outputs are registered and update only on the rising edge of clk. There are no combinational input-to-output paths.
- Reset:
  - rst is sampled at the rising edge of clk.
  - When rst=1 at an edge, that edge sets enc_o=2'b00, valid_o=0, err_o=0.
  - rst has priority over enc_i.
  - Asserting rst mid-stream discards the input sampled at that edge. Normal operation resumes on the first edge with rst=0.
- Latency: exactly 1 cycle. Values on enc_i at edge k appear on the outputs after edge k and hold until edge k+1.
- One-hot encoding, non-reset edges:
  - 4'b0001 -> enc_o=2'b00
  - 4'b0010 -> enc_o=2'b01
  - 4'b0100 -> enc_o=2'b10
  - 4'b1000 -> enc_o=2'b11
  - For all of these: valid_o=1, err_o=0.
- All-zero input: 4'b0000 -> enc_o=2'b00, valid_o=0, err_o=0. enc_o is forced to 00 and does not hold its previous value.
- Multi-hot input (two or more bits set):
  - valid_o=1, err_o=1.
  - With PRIORITY_MSB=1, enc_o is the index of the highest set bit. Example: 4'b0110 -> 2'b10; 4'b1111 -> 2'b11.
  - With PRIORITY_MSB=0, enc_o is the index of the lowest set bit. Example: 4'b0110 -> 2'b01; 4'b1111 -> 2'b00.
- err_o is a popcount>1 detect and does not depend on PRIORITY_MSB.
- No internal state beyond the three output registers. Back-to-back changes on consecutive cycles are each encoded independently.
- X/Z on enc_i is not supported. Behaviour is undefined unless enc_i is fully driven at each sampling edge.
- Power-up, before the first reset: outputs are undefined. The bench must assert rst for at least 1 cycle first.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with enc_i=4'b1000 -> after each edge enc_o=00, valid_o=0, err_o=0.
2. One-hot sweep, rst=0: apply 4'b0001, 4'b0010, 4'b0100, 4'b1000 on consecutive cycles -> one cycle later, successively enc_o=00, 01, 10, 11, each with valid_o=1 and err_o=0.
3. Zero input: after enc_i=4'b1000, apply 4'b0000 -> next cycle enc_o=00, valid_o=0, err_o=0.
4. Multi-hot, PRIORITY_MSB=1: 4'b0110 -> enc_o=10, valid_o=1, err_o=1. Then 4'b1111 -> enc_o=11, err_o=1. Repeat with PRIORITY_MSB=0: 4'b0110 -> 01, then 4'b1111 -> 00, both with err_o=1.
5. Reset mid-stream: with enc_i=4'b0100, assert rst for one edge -> outputs 00/0/0 at that edge. Deassert rst -> the next edge gives enc_o=10, valid_o=1.
6. Exhaustive check: drive all 16 enc_i values, one per cycle, for both PRIORITY_MSB values. Compare outputs against a reference model with 1-cycle delay. Outputs must not change between clock edges.
